// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and op-decode helpers for the RV32M unit
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM;
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return op == OP_MULH || op == OP_DIV || op == OP_REM;
  endfunction

  function automatic logic wants_high(input logic [2:0] op);
    return !(op == OP_MUL || op == OP_DIV || op == OP_DIVU);
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add (multiply) or restoring shift-subtract (divide) iteration
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_n,
  output logic [XLEN-1:0] lo_n
);
  logic [XLEN:0] sum, shl, dif;

  assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
  assign shl  = {hi, lo[XLEN-1]};
  assign dif  = shl - {1'b0, b};
  assign hi_n = div ? (dif[XLEN] ? shl[XLEN-1:0] : dif[XLEN-1:0]) : sum[XLEN:1];
  assign lo_n = div ? {lo[XLEN-2:0], ~dif[XLEN]} : {sum[0], lo[XLEN-1:1]};
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with valid/ready issue and tagged result
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);
  localparam int ITER = XLEN / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  if (!(BITS_PER_CYCLE inside {1, 2, 4}) || (XLEN % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("BITS_PER_CYCLE must be 1, 2 or 4 and divide XLEN");
  end

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, b;
  logic [2:0]      op;
  logic            neg;
  logic [4:0]      rd;
  logic [XLEN-1:0] hi_c [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] lo_c [BITS_PER_CYCLE+1];

  assign hi_c[0] = hi;
  assign lo_c[0] = lo;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .div  (is_div(op)),
      .hi   (hi_c[i]),
      .lo   (lo_c[i]),
      .b    (b),
      .hi_n (hi_c[i+1]),
      .lo_n (lo_c[i+1])
    );
  end

  logic            accept, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_res, half, half_s, fix_res;
  logic [2*XLEN-1:0] full, full_s;

  assign accept      = valid_i & (state == IDLE) & ~flush_i;
  assign a_neg       = is_signed_a(op_i) & rs1_i[XLEN-1];
  assign b_neg       = is_signed_b(op_i) & rs2_i[XLEN-1];
  assign mag_a       = a_neg ? -rs1_i : rs1_i;
  assign mag_b       = b_neg ? -rs2_i : rs2_i;
  assign div_zero    = is_div(op_i) & (rs2_i == '0);
  assign ovf         = is_div(op_i) & is_signed_b(op_i) & (rs1_i == MIN_VAL) & (rs2_i == '1);
  assign special_res = div_zero ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : rs1_i);
  assign full        = {hi, lo};
  assign full_s      = neg ? -full : full;
  assign half        = wants_high(op) ? hi : lo;
  assign half_s      = neg ? -half : half;
  assign fix_res     = is_div(op) ? half_s : (wants_high(op) ? full_s[2*XLEN-1:XLEN] : full_s[XLEN-1:0]);

  assign ready_o = state == IDLE;
  assign busy_o  = state != IDLE;
  assign done_o  = (state == DONE) & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      b        <= '0;
      op       <= '0;
      neg      <= 1'b0;
      rd       <= '0;
      result_o <= '0;
      rd_o     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op  <= op_i;
          rd  <= rd_i;
          cnt <= CW'(ITER);
          hi  <= '0;
          lo  <= is_div(op_i) ? mag_a : mag_b;
          b   <= is_div(op_i) ? mag_b : mag_a;
          neg <= (is_div(op_i) && op_i[1]) ? a_neg : a_neg ^ b_neg;
          if (div_zero || ovf) begin
            result_o <= special_res;
            rd_o     <= rd_i;
            state    <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: if (flush_i) begin
          state <= IDLE;
        end else begin
          hi  <= hi_c[BITS_PER_CYCLE];
          lo  <= lo_c[BITS_PER_CYCLE];
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: if (flush_i) begin
          state <= IDLE;
        end else begin
          result_o <= fix_res;
          rd_o     <= rd;
          state    <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven and sequence checks of muldiv_unit at 1 and 4 bits per cycle
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          sp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        valid [2];
  logic        ready [2];
  logic        busy  [2];
  logic        done  [2];
  logic [31:0] res   [2];
  logic [4:0]  rdo   [2];
  int          checks = 0;
  int          fails  = 0;
  int          lat_n  [2] = '{34, 10};
  vec_t        vecs   [20];

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid[0]), .op_i(op),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .ready_o(ready[0]), .busy_o(busy[0]),
    .done_o(done[0]), .result_o(res[0]), .rd_o(rdo[0])
  );

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid[1]), .op_i(op),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .ready_o(ready[1]), .busy_o(busy[1]),
    .done_o(done[1]), .result_o(res[1]), .rd_o(rdo[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int s);
    int w = 0;
    @(negedge clk);
    while (!ready[s] && w < 50) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic wait_done(input int s, output int n, output logic busy_ok);
    n = 1;
    busy_ok = 1'b1;
    while (!done[s] && n < 100) begin
      busy_ok &= busy[s];
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic run_op(input int s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] bb,
                        input logic [4:0] t, input logic [31:0] exp, input int lat, input string name);
    int   n;
    logic busy_ok;
    wait_ready(s);
    check({name, " ready"}, 32'(ready[s]), 32'd1);
    op = o; rs1 = a; rs2 = bb; rd = t; valid[s] = 1'b1;
    @(posedge clk);
    #1 valid[s] = 1'b0;
    op = ~o; rs1 = ~a; rs2 = ~bb; rd = ~t;
    wait_done(s, n, busy_ok);
    check({name, " latency"}, 32'(n), 32'(lat));
    check({name, " result"}, res[s], exp);
    check({name, " rd"}, 32'(rdo[s]), 32'(t));
    check({name, " busy"}, 32'(busy_ok), 32'd1);
  endtask

  task automatic check_reset(input int s, input string name);
    check({name, " ready"}, 32'(ready[s]), 32'd1);
    check({name, " busy"}, 32'(busy[s]), 32'd0);
    check({name, " done"}, 32'(done[s]), 32'd0);
    check({name, " result"}, res[s], 32'd0);
    check({name, " rd"}, 32'(rdo[s]), 32'd0);
  endtask

  initial begin
    int   n;
    logic busy_ok, saw_done;
    logic [31:0] prev;
    vecs[0]  = '{OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    vecs[2]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{OP_DIVU,   32'd100,      32'd7,        32'd14,       1'b0};
    vecs[7]  = '{OP_REMU,   32'd100,      32'd7,        32'd2,        1'b0};
    vecs[8]  = '{OP_DIVU,   32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{OP_REM,    32'h00001234, 32'h00000000, 32'h00001234, 1'b1};
    vecs[10] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[11] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[12] = '{OP_MULH,   32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 1'b0};
    vecs[13] = '{OP_MULHU,  32'h00010000, 32'h00010000, 32'h00000001, 1'b0};
    vecs[14] = '{OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[15] = '{OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[16] = '{OP_DIV,    32'h80000000, 32'h00000002, 32'hC0000000, 1'b0};
    vecs[17] = '{OP_REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0};
    vecs[18] = '{OP_MULHSU, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    vecs[19] = '{OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 1'b0};

    rst = 1'b1; flush = 1'b0; valid[0] = 1'b0; valid[1] = 1'b0;
    op = '0; rs1 = '0; rs2 = '0; rd = '0;
    repeat (2) @(posedge clk);
    #1 check_reset(0, "reset1");
    check_reset(1, "reset4");
    rst = 1'b0;

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 20; i++)
        run_op(s, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 5), vecs[i].exp,
               vecs[i].sp ? 1 : lat_n[s], $sformatf("vec%0d_bpc%0d", i, s == 0 ? 1 : 4));

    // flush mid-CALC: no strobe, unit idle next edge, previous result kept
    wait_ready(0);
    prev = res[0];
    op = OP_MUL; rs1 = 32'd3; rs2 = 32'd5; rd = 5'd9; valid[0] = 1'b1;
    @(posedge clk);
    #1 valid[0] = 1'b0;
    saw_done = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1 saw_done |= done[0];
    end
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush ready", 32'(ready[0]), 32'd1);
    check("flush busy", 32'(busy[0]), 32'd0);
    check("flush result", res[0], prev);
    repeat (40) begin
      @(posedge clk);
      #1 saw_done |= done[0];
    end
    check("flush no done", 32'(saw_done), 32'd0);

    // flush during DONE only masks the strobe
    wait_ready(0);
    op = OP_DIVU; rs1 = 32'd1; rs2 = 32'd0; rd = 5'd2; valid[0] = 1'b1;
    @(posedge clk);
    #1 valid[0] = 1'b0;
    check("done strobe", 32'(done[0]), 32'd1);
    flush = 1'b1;
    #1 check("done masked", 32'(done[0]), 32'd0);
    flush = 1'b0;

    // reset mid-CALC
    wait_ready(0);
    op = OP_MULHU; rs1 = 32'hDEADBEEF; rs2 = 32'h12345678; rd = 5'd17; valid[0] = 1'b1;
    @(posedge clk);
    #1 valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check_reset(0, "midreset");
    rst = 1'b0;

    // back-to-back issue with valid held: one IDLE bubble between ops
    wait_ready(1);
    op = OP_DIVU; rs1 = 32'd5; rs2 = 32'd0; rd = 5'd3; valid[1] = 1'b1;
    @(posedge clk);
    #1 check("b2b first done", 32'(done[1]), 32'd1);
    check("b2b first result", res[1], 32'hFFFFFFFF);
    op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd4;
    @(posedge clk);
    #1 check("b2b bubble ready", 32'(ready[1]), 32'd1);
    @(posedge clk);
    #1 check("b2b second accepted", 32'(busy[1]), 32'd1);
    valid[1] = 1'b0;
    wait_done(1, n, busy_ok);
    check("b2b latency", 32'(n), 32'd10);
    check("b2b result", res[1], 32'd14);
    check("b2b rd", 32'(rdo[1]), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
